// File: rtl/l1_device_responder.sv
// Device-side L1 interconnect endpoint: one peripheral access per request, responses queued in a
// credit-protected FIFO. Define L1_RESP_BYPASS_EN to let a response skip an empty FIFO.
module l1_resp_fifo #(
  parameter int Width = 33,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic             empty,
  output logic [Width-1:0] rdata
);
  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  // Extra MSB on each pointer distinguishes full from empty after wrap.
  logic [PtrW:0]    wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PtrW-1:0]] <= wdata;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module l1_device_responder #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 20,
  parameter int NbrHostsLog2 = 1,
  parameter int FifoDepth    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [NbrHostsLog2-1:0] req_ini_addr_i,
  input  logic [AddrWidth-1:0]    req_tgt_addr_i,
  input  logic                    req_wen_i,
  input  logic [DataWidth-1:0]    req_wdata_i,
  input  logic [DataWidth/8-1:0]  req_be_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [NbrHostsLog2-1:0] resp_ini_addr_o,
  output logic [DataWidth-1:0]    resp_rdata_o,
  output logic                    dev_req_o,
  output logic                    dev_we_o,
  output logic [DataWidth/8-1:0]  dev_be_o,
  output logic [31:0]             dev_addr_o,
  output logic [DataWidth-1:0]    dev_wdata_o,
  input  logic                    dev_rvalid_i,
  input  logic [DataWidth-1:0]    dev_rdata_i
);
  localparam int CntW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [NbrHostsLog2-1:0] ini;
    logic [DataWidth-1:0]    data;
  } resp_t;

  logic [CntW-1:0]         count;
  logic                    inflight_v, inflight_wen;
  logic [NbrHostsLog2-1:0] inflight_ini;
  logic                    acc, push, pop, discard, byp_take, empty;
  resp_t                   dev_resp, head, resp;

  // Credits cover every accepted request until its response leaves, so a push never overflows.
  assign req_ready_o = (count < CntW'(FifoDepth)) & ~rst_i;
  assign acc         = req_valid_i & req_ready_o;

  assign dev_req_o   = acc;
  assign dev_we_o    = req_wen_i;
  assign dev_be_o    = req_be_i;
  assign dev_addr_o  = 32'(req_tgt_addr_i);
  assign dev_wdata_o = req_wdata_i;

  assign dev_resp.ini  = inflight_ini;
  assign dev_resp.data = inflight_wen ? '0 : dev_rdata_i;

  assign pop     = ~empty & resp_ready_i;
  assign discard = inflight_v & ~dev_rvalid_i;

`ifdef L1_RESP_BYPASS_EN
  logic byp_valid;
  assign byp_valid    = empty & inflight_v & dev_rvalid_i;
  assign byp_take     = byp_valid & resp_ready_i;
  assign resp_valid_o = ~empty | byp_valid;
  assign resp         = byp_valid ? dev_resp : head;
`else
  assign byp_take     = 1'b0;
  assign resp_valid_o = ~empty;
  assign resp         = head;
`endif

  assign push            = inflight_v & dev_rvalid_i & ~byp_take;
  assign resp_ini_addr_o = resp.ini;
  assign resp_rdata_o    = resp.data;

  l1_resp_fifo #(
    .Width ($bits(resp_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (dev_resp),
    .pop   (pop),
    .empty (empty),
    .rdata (head)
  );

  // A missing peripheral reply and a FIFO pop may both release a credit in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count        <= '0;
      inflight_v   <= 1'b0;
      inflight_wen <= 1'b0;
      inflight_ini <= '0;
    end else begin
      count      <= count + CntW'(acc) - CntW'(pop) - CntW'(discard) - CntW'(byp_take);
      inflight_v <= acc;
      if (acc) begin
        inflight_wen <= req_wen_i;
        inflight_ini <= req_ini_addr_i;
      end
    end
  end
endmodule
